// File: rtl/ws2812b_pkg.sv
// Shared WS2812B definitions: receiver FSM states and 9 MHz protocol timing defaults.
package ws2812b_pkg;

  typedef enum logic [1:0] {
    WAIT_RET,
    READY,
    HIGH,
    LOW
  } rx_state_e;

  localparam int unsigned BITS_PER_LED = 24;

  localparam int unsigned CYCLES_SHORT = 3;
  localparam int unsigned CYCLES_LONG  = 5;
  localparam int unsigned CYCLES_RET   = 450;

endpackage

// File: rtl/ws2812b_rx_sync.sv
// Two-flop synchroniser for an asynchronous line plus registered-edge rise/fall strobes.
module ws2812b_rx_sync (
  input  logic clk,
  input  logic resetn,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = din;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign dout = sync_q;
  assign rise = sync_q & ~prev_q;
  assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/ws2812b_rx_module.sv
// WS2812B receiver behaving as one LED of a chain: decodes pulses, captures its pixel, detects latch.
// Optional macro WS2812B_RX_FORWARD_EN builds the downstream forwarding path (else ws2812b_fwd = 0).
module ws2812b_rx_module
  import ws2812b_pkg::*;
#(
  parameter int unsigned CYCLES_THRESHOLD = 4,
  parameter int unsigned CYCLES_MAX_HIGH  = 12,
  parameter int unsigned CYCLES_RET       = 450,
  parameter int unsigned CYCLES_CNT_WIDTH = 9,
  parameter int unsigned CAPTURE_ALL      = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ws2812b_in,
  output logic [23:0] bitstream,
  output logic        bitstream_valid,
  output logic [7:0]  pixel_index,
  output logic        frame_end,
  output logic        error,
  output logic        ws2812b_fwd
);

  localparam int unsigned W = CYCLES_CNT_WIDTH;
  localparam logic [W-1:0] THR_C      = W'(CYCLES_THRESHOLD);
  localparam logic [W-1:0] MAX_HIGH_C = W'(CYCLES_MAX_HIGH);
  localparam logic [W-1:0] RET_C      = W'(CYCLES_RET);
  localparam logic [4:0]   LAST_BIT_C = 5'(BITS_PER_LED - 1);

  logic line, rise, fall;

  ws2812b_rx_sync u_sync (
    .clk   (clk),
    .resetn(resetn),
    .din   (ws2812b_in),
    .dout  (line),
    .rise  (rise),
    .fall  (fall)
  );

  rx_state_e   state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [23:0] shreg_q, shreg_d;
  logic        captured_q, captured_d;
  logic [7:0]  grp_cnt_q, grp_cnt_d;
  logic        report_q, report_d;
  logic [7:0]  report_idx_q, report_idx_d;
  logic [23:0] bitstream_q, bitstream_d;
  logic        valid_q, valid_d;
  logic [7:0]  pixel_index_q, pixel_index_d;
  logic        frame_end_q, frame_end_d;
  logic        error_q, error_d;

  always_comb begin
    cnt_d = cnt_q;
    if (rise || fall)
      cnt_d = W'(1);
    else if (cnt_q != '1)
      cnt_d = cnt_q + W'(1);
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    captured_d   = captured_q;
    grp_cnt_d    = grp_cnt_q;
    report_d     = 1'b0;
    report_idx_d = report_idx_q;
    frame_end_d  = 1'b0;
    error_d      = 1'b0;
    unique case (state_q)
      WAIT_RET: begin
        if (!line && cnt_q >= RET_C)
          state_d = READY;
      end
      READY: begin
        if (rise)
          state_d = HIGH;
      end
      HIGH: begin
        // Overlong high beats a coincident falling edge.
        if (cnt_q > MAX_HIGH_C) begin
          error_d    = 1'b1;
          state_d    = WAIT_RET;
          bit_cnt_d  = '0;
          captured_d = 1'b0;
          grp_cnt_d  = '0;
        end else if (fall) begin
          shreg_d = {shreg_q[22:0], (cnt_q >= THR_C)};
          state_d = LOW;
          if (bit_cnt_q == LAST_BIT_C) begin
            bit_cnt_d = '0;
            if (CAPTURE_ALL != 0) begin
              report_d     = 1'b1;
              report_idx_d = grp_cnt_q;
              if (grp_cnt_q != '1)
                grp_cnt_d = grp_cnt_q + 8'd1;
            end else if (!captured_q) begin
              report_d     = 1'b1;
              report_idx_d = '0;
              captured_d   = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end
      LOW: begin
        if (rise) begin
          state_d = HIGH;
        end else if (cnt_q >= RET_C) begin
          frame_end_d = 1'b1;
          error_d     = (bit_cnt_q != '0);
          state_d     = READY;
          bit_cnt_d   = '0;
          captured_d  = 1'b0;
          grp_cnt_d   = '0;
        end
      end
      default: state_d = WAIT_RET;
    endcase
  end

  always_comb begin
    bitstream_d   = bitstream_q;
    valid_d       = report_q;
    pixel_index_d = pixel_index_q;
    if (report_q) begin
      bitstream_d   = shreg_q;
      pixel_index_d = report_idx_q;
    end
    if (frame_end_d)
      pixel_index_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= WAIT_RET;
      cnt_q         <= '0;
      bit_cnt_q     <= '0;
      shreg_q       <= '0;
      captured_q    <= 1'b0;
      grp_cnt_q     <= '0;
      report_q      <= 1'b0;
      report_idx_q  <= '0;
      bitstream_q   <= '0;
      valid_q       <= 1'b0;
      pixel_index_q <= '0;
      frame_end_q   <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shreg_q       <= shreg_d;
      captured_q    <= captured_d;
      grp_cnt_q     <= grp_cnt_d;
      report_q      <= report_d;
      report_idx_q  <= report_idx_d;
      bitstream_q   <= bitstream_d;
      valid_q       <= valid_d;
      pixel_index_q <= pixel_index_d;
      frame_end_q   <= frame_end_d;
      error_q       <= error_d;
    end
  end

  assign bitstream       = bitstream_q;
  assign bitstream_valid = valid_q;
  assign pixel_index     = pixel_index_q;
  assign frame_end       = frame_end_q;
  assign error           = error_q;

`ifdef WS2812B_RX_FORWARD_EN
  // The forwarding enable is exactly the captured flag: set when the first group
  // completes (line low), cleared on frame end or error; never set in capture-all mode.
  logic fwd_q, fwd_d;

  always_comb begin
    fwd_d = line & captured_q & (CAPTURE_ALL == 0);
  end

  always_ff @(posedge clk) begin
    if (!resetn)
      fwd_q <= 1'b0;
    else
      fwd_q <= fwd_d;
  end

  assign ws2812b_fwd = fwd_q;
`else
  assign ws2812b_fwd = 1'b0;
`endif

endmodule
